// File: rtl/load_store_unit_if.sv
// Request/response handshake and DataMemory bus of the load/store unit.
// Signal names follow the execute-stage and DataMemory port names.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        MemReadEn;
  logic        MemWriteEn;
  logic [31:0] AddressBus;
  logic [31:0] DataMemoryInput;
  logic [31:0] DataMemoryOutput;

  // Handshake: a request transfers on a posedge where req_valid and req_ready are both
  // high; req_* are ignored whenever req_ready is low. rsp_valid is a single-cycle pulse
  // that cannot be back-pressured; rsp_rdata/rsp_err stay stable until the next pulse.
  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, DataMemoryOutput,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  MemReadEn, MemWriteEn, AddressBus, DataMemoryInput
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, DataMemoryOutput,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output MemReadEn, MemWriteEn, AddressBus, DataMemoryInput
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: word-aligned DataMemory accesses, lane extraction/extension
// on loads, read-modify-write for SB/SH, and error flagging before any memory access.
module load_store_unit #(
  parameter int MEM_BITS = 10
) (
  input  logic             clock,
  input  logic             reset,
  load_store_unit_if.slave bus,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_RMW_WR = 3'd3,
    S_WR     = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_RANGE    = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic        illegal_f3;
  logic        range_bad;
  logic        misaligned;
  logic [1:0]  accept_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_value;
  logic [31:0] merge_word;

  // Request checks are evaluated on the live inputs; they only matter in the accept cycle.
  always_comb begin
    illegal_f3 = 1'b0;
    misaligned = 1'b0;
    accept_err = ERR_OK;
    if (bus.req_store) begin
      illegal_f3 = (bus.req_funct3 > 3'b010);
    end else begin
      illegal_f3 = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    end
    range_bad = |bus.req_addr[31:MEM_BITS];
    case (bus.req_funct3[1:0])
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    if (illegal_f3) begin
      accept_err = ERR_FUNCT3;
    end else if (range_bad) begin
      accept_err = ERR_RANGE;
    end else if (misaligned) begin
      accept_err = ERR_MISALIGN;
    end
  end

  // Little-endian lane selection and extension of the word returned in RD.
  always_comb begin
    lane_byte  = 8'h00;
    load_value = 32'h0000_0000;
    case (addr_q[1:0])
      2'd0:    lane_byte = bus.DataMemoryOutput[7:0];
      2'd1:    lane_byte = bus.DataMemoryOutput[15:8];
      2'd2:    lane_byte = bus.DataMemoryOutput[23:16];
      default: lane_byte = bus.DataMemoryOutput[31:24];
    endcase
    lane_half = addr_q[1] ? bus.DataMemoryOutput[31:16] : bus.DataMemoryOutput[15:0];
    case (funct3_q)
      3'b000:  load_value = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_value = {{16{lane_half[15]}}, lane_half};
      3'b010:  load_value = bus.DataMemoryOutput;
      3'b100:  load_value = {24'h00_0000, lane_byte};
      3'b101:  load_value = {16'h0000, lane_half};
      default: load_value = 32'h0000_0000;
    endcase
  end

  // The old word sits in buf_q; only the addressed byte or half is replaced.
  always_comb begin
    merge_word = buf_q;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merge_word[7:0]   = wdata_q[7:0];
        2'd1:    merge_word[15:8]  = wdata_q[7:0];
        2'd2:    merge_word[23:16] = wdata_q[7:0];
        default: merge_word[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_word[31:16] = wdata_q[15:0];
    end else begin
      merge_word[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d             = state_q;
    addr_d              = addr_q;
    funct3_d            = funct3_q;
    wdata_d             = wdata_q;
    buf_d               = buf_q;
    rdata_d             = rdata_q;
    err_d               = err_q;
    bus.req_ready       = 1'b0;
    bus.rsp_valid       = 1'b0;
    bus.MemReadEn       = 1'b0;
    bus.MemWriteEn      = 1'b0;
    bus.DataMemoryInput = 32'h0000_0000;

    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          funct3_d = bus.req_funct3;
          wdata_d  = bus.req_wdata;
          buf_d    = 32'h0000_0000;
          if (accept_err != ERR_OK) begin
            err_d   = accept_err;
            rdata_d = 32'h0000_0000;
            state_d = S_RESP;
          end else if (!bus.req_store) begin
            state_d = S_RD;
          end else if (bus.req_funct3[1:0] == 2'b10) begin
            state_d = S_WR;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_RD: begin
        bus.MemReadEn = 1'b1;
        rdata_d       = load_value;
        err_d         = ERR_OK;
        state_d       = S_RESP;
      end
      S_RMW_RD: begin
        bus.MemReadEn = 1'b1;
        buf_d         = bus.DataMemoryOutput;
        state_d       = S_RMW_WR;
      end
      S_RMW_WR: begin
        bus.MemWriteEn      = 1'b1;
        bus.DataMemoryInput = merge_word;
        rdata_d             = 32'h0000_0000;
        err_d               = ERR_OK;
        state_d             = S_RESP;
      end
      S_WR: begin
        bus.MemWriteEn      = 1'b1;
        bus.DataMemoryInput = wdata_q;
        rdata_d             = 32'h0000_0000;
        err_d               = ERR_OK;
        state_d             = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'h0000_0000;
      funct3_q <= 3'b000;
      wdata_q  <= 32'h0000_0000;
      buf_q    <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_err    = err_q;
  assign bus.AddressBus = {addr_q[31:2], 2'b00};
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array DataMemory, directed RV32I cases with literal
// expectations, then random requests checked every cycle against a byte-level model.
module tb_load_store_unit;
  localparam int MEM_BITS  = 10;
  localparam int MEM_BYTES = 1 << MEM_BITS;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BITS(MEM_BITS)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] dmem    [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  // Model of the outstanding request (response = {rdata, err})
  logic [33:0] exp_q[$];
  bit          busy = 1'b0;
  int          rem = 0;
  int          pend_reads = 0, pend_writes = 0;
  int          rd_seen = 0, wr_seen = 0;
  bit          pend_commit = 1'b0;
  int          pend_base = 0, pend_size = 0;
  logic [31:0] pend_wdata = '0, pend_bus_addr = '0, pend_word = '0;
  logic [31:0] last_rdata = '0;
  logic [1:0]  last_err = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dword(input int a);
    return {dmem[a+3], dmem[a+2], dmem[a+1], dmem[a]};
  endfunction

  // Outcome of a request from the architectural rules, reading the reference memory.
  task automatic model_accept(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd);
    int         size, base, wb, lat;
    longint     v;
    logic [1:0] err;
    logic [31:0] w;
    size = 1 << f3[1:0];
    if ((!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) || (st && f3 > 3'd2)) err = 2'b10;
    else if (a >= 32'(MEM_BYTES)) err = 2'b11;
    else if (a % 32'(size) != 0) err = 2'b01;
    else err = 2'b00;
    base          = int'(a[MEM_BITS-1:0]);
    wb            = base & ~3;
    pend_bus_addr = {a[31:2], 2'b00};
    pend_reads    = 0;
    pend_writes   = 0;
    pend_commit   = 1'b0;
    pend_word     = '0;
    v             = 0;
    if (err != 2'b00) begin
      lat = 1;
    end else if (!st) begin
      for (int i = 0; i < size; i++) v = v + (longint'(ref_mem[base+i]) << (8 * i));
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      pend_reads = 1;
      lat        = 2;
    end else begin
      w = {ref_mem[wb+3], ref_mem[wb+2], ref_mem[wb+1], ref_mem[wb]};
      for (int i = 0; i < size; i++) w[8*((base % 4) + i) +: 8] = wd[8*i +: 8];
      pend_word   = w;
      pend_writes = 1;
      pend_reads  = (size < 4) ? 1 : 0;
      lat         = (size < 4) ? 3 : 2;
      pend_commit = 1'b1;
      pend_base   = base;
      pend_size   = size;
      pend_wdata  = wd;
    end
    exp_q.push_back({v[31:0], err});
    busy    = 1'b1;
    rem     = lat - 1;
    rd_seen = 0;
    wr_seen = 0;
  endtask

  // DataMemory environment plus the single per-cycle compare process
  initial begin
    int          wa;
    bit          exp_rsp;
    logic [33:0] e;
    for (int i = 0; i < MEM_BYTES; i++) begin
      dmem[i]    = 8'($urandom_range(0, 255));
      ref_mem[i] = dmem[i];
    end
    dmem[16'h10] = 8'h80; dmem[16'h11] = 8'h7F; dmem[16'h12] = 8'h34; dmem[16'h13] = 8'h12;
    for (int i = 16'h10; i < 16'h14; i++) ref_mem[i] = dmem[i];
    bus.DataMemoryOutput = '0;
    forever begin
      @(negedge clock);
      wa = int'({bus.AddressBus[MEM_BITS-1:2], 2'b00});
      if (bus.MemWriteEn) for (int i = 0; i < 4; i++) dmem[wa+i] = bus.DataMemoryInput[8*i +: 8];
      if (bus.MemReadEn) bus.DataMemoryOutput = dword(wa);

      if (reset) begin
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_mem_en", {30'd0, bus.MemReadEn, bus.MemWriteEn}, 32'd0);
        check("rst_addr_bus", bus.AddressBus, 32'd0);
        check("rst_mem_in", bus.DataMemoryInput, 32'd0);
        busy       = 1'b0;
        exp_q.delete();
        last_rdata = '0;
        last_err   = '0;
      end else begin
        check("req_ready", 32'(bus.req_ready), 32'(!busy));
        if (bus.MemReadEn) rd_seen++;
        if (bus.MemWriteEn) wr_seen++;
        if (!busy) begin
          check("idle_mem_en", {30'd0, bus.MemReadEn, bus.MemWriteEn}, 32'd0);
        end else begin
          if (bus.MemReadEn || bus.MemWriteEn) check("addr_bus", bus.AddressBus, pend_bus_addr);
          if (bus.MemWriteEn) check("mem_wdata", bus.DataMemoryInput, pend_word);
        end
        exp_rsp = busy && (rem == 0);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
        if (exp_rsp) begin
          if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd1, 32'd0);
          end else begin
            e          = exp_q.pop_front();
            last_rdata = e[33:2];
            last_err   = e[1:0];
          end
          check("mem_reads", 32'(rd_seen), 32'(pend_reads));
          check("mem_writes", 32'(wr_seen), 32'(pend_writes));
          if (pend_commit)
            for (int i = 0; i < pend_size; i++) ref_mem[pend_base+i] = pend_wdata[8*i +: 8];
        end
        check("rsp_rdata", bus.rsp_rdata, last_rdata);
        check("rsp_err", 32'(bus.rsp_err), 32'(last_err));
        if (busy) begin
          if (rem == 0) busy = 1'b0;
          else rem--;
        end else if (bus.req_valid) begin
          model_accept(bus.req_store, bus.req_funct3, bus.req_addr, bus.req_wdata);
        end
      end
    end
  end

  task automatic scramble_req();
    bus.req_store  = 1'($urandom_range(0, 1));
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  // Issue one request; with chk set, also pin latency and response to literal values.
  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input bit scramble, input bit chk,
                      input int exp_lat, input logic [31:0] exp_rdata,
                      input logic [1:0] exp_err, input string name);
    bit got;
    int lat;
    @(posedge clock); #1;
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clock);
      if (bus.req_ready) got = 1'b1;
    end
    if (!got) begin
      $display("FAIL %s_accept_timeout: req_ready never high", name);
      n_checks++;
      n_errors++;
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    if (scramble) scramble_req();
    else bus.req_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clock);
      lat++;
      if (bus.rsp_valid) got = 1'b1;
      else if (scramble) scramble_req();
    end
    if (!got) begin
      $display("FAIL %s_rsp_timeout: no rsp_valid within 10 cycles", name);
      n_checks++;
      n_errors++;
    end else if (chk) begin
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_rdata"}, bus.rsp_rdata, exp_rdata);
      check({name, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    end
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    logic        st;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    send(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 1'b1, 2, 32'hFFFF_FF80, 2'b00, "lb");
    send(1'b0, 3'b100, 32'h10, 32'h0, 1'b0, 1'b1, 2, 32'h0000_0080, 2'b00, "lbu");
    send(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 1'b1, 2, 32'h0000_1234, 2'b00, "lh");
    send(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, 2, 32'h1234_7F80, 2'b00, "lw");
    send(1'b1, 3'b000, 32'h11, 32'hAABB_CCDD, 1'b0, 1'b1, 3, 32'h0, 2'b00, "sb");
    check("sb_word", dword(16'h10), 32'h1234_DD80);
    send(1'b1, 3'b001, 32'h13, 32'h5555_6666, 1'b0, 1'b1, 1, 32'h0, 2'b01, "sh_misaligned");
    check("sh_misaligned_word", dword(16'h10), 32'h1234_DD80);
    send(1'b0, 3'b010, 32'h400, 32'h0, 1'b0, 1'b1, 1, 32'h0, 2'b11, "lw_range");
    send(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, 1'b1, 1, 32'h0, 2'b10, "ld_funct3");
    send(1'b1, 3'b011, 32'h401, 32'h0, 1'b0, 1'b1, 1, 32'h0, 2'b10, "st_funct3_prio");
    send(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 1'b0, 1'b1, 2, 32'h0, 2'b00, "sw");
    send(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 1'b1, 2, 32'hDEAD_BEEF, 2'b00, "lw_b2b");
    send(1'b0, 3'b101, 32'h22, 32'h0, 1'b0, 1'b1, 2, 32'h0000_DEAD, 2'b00, "lhu");

    // Reset lands in RMW_WR ahead of its negedge, so the write must not happen.
    @(posedge clock); #1;
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h0000_0055;
    @(negedge clock);
    check("rmw_rst_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rmw_rst_word", dword(16'h10), 32'h1234_DD80);
    @(posedge clock); #1;
    reset = 1'b0;
    send(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, 2, 32'h1234_DD80, 2'b00, "lw_after_rst");

    send(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b1, 2, 32'hDEAD_BEEF, 2'b00, "lw_scramble");
    send(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 1'b1, 1'b1, 3, 32'h0, 2'b00, "sh_scramble");
    send(1'b0, 3'b000, 32'h23, 32'h0, 1'b0, 1'b1, 2, 32'hFFFF_FFBE, 2'b00, "lb_hi");

    for (int n = 0; n < 400; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, MEM_BYTES - 1));
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      send(st, f3, a, $urandom, ($urandom_range(0, 3) == 0), 1'b0, 0, 32'h0, 2'b00, "rand");
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end

    repeat (3) @(posedge clock);
    for (int i = 0; i < MEM_BYTES; i += 4)
      check("final_mem", dword(i), {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
